// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard control unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int BRANCH_EX  = 2;
  localparam int BRANCH_MEM = 3;

  // Shadow entries are sized for the widest supported configuration; narrower
  // configurations zero-extend into them.
  localparam int MAX_ADDR_W = 6;
  localparam int MAX_SRC    = 4;

  typedef struct packed {
    logic                               valid;
    logic [MAX_ADDR_W-1:0]              rd;
    logic                               regwrite;
    logic                               memread;
    logic [MAX_SRC-1:0][MAX_ADDR_W-1:0] rs;
    logic [MAX_SRC-1:0]                 rs_used;
  } shadow_entry_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUSY,
    ACT_LOAD_USE,
    ACT_NORMAL
  } action_e;

  function automatic logic writes_reg(shadow_entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

endpackage

// File: rtl/forward_select.sv
// rtl/forward_select.sv - forwarding source select for one EX operand, MEM over WB
module forward_select
  import hazard_pkg::*;
(
  input  logic [MAX_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  shadow_entry_t         mem_entry,
  input  shadow_entry_t         wb_entry,
  output fwd_sel_e              sel
);

  always_comb begin
    sel = FWD_REG;
    if (src_used && writes_reg(mem_entry) && (mem_entry.rd == src)) begin
      sel = FWD_MEM;
    end else if (src_used && writes_reg(wb_entry) && (wb_entry.rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - forwarding, load-use stall, branch flush and busy control for a 5-stage pipeline
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int BRANCH_STAGE = 3,
  parameter int CNT_W        = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          branch_taken,
  input  logic                          ex_busy,
  output logic                          pc_write,
  output logic                          ifid_write,
  output logic                          ifid_flush,
  output logic                          idex_bubble,
  output logic                          idex_write,
  output logic                          exmem_bubble,
  output logic                          ex_kill,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  if (BRANCH_STAGE != BRANCH_EX && BRANCH_STAGE != BRANCH_MEM) begin : g_bad_branch_stage
    $error("hazard_control_unit: BRANCH_STAGE must be 2 (EX) or 3 (MEM)");
  end
  if (REG_ADDR_W > MAX_ADDR_W || NUM_SRC > MAX_SRC) begin : g_bad_width
    $error("hazard_control_unit: REG_ADDR_W or NUM_SRC exceeds shadow entry size");
  end

  shadow_entry_t ex_q, mem_q, wb_q;
  shadow_entry_t id_entry;
  action_e       action;
  logic          id_hit;
  logic          load_use;

  // Source enables are masked with id_valid so an empty slot never forwards or stalls.
  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.rd       = MAX_ADDR_W'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_entry.rs[i]      = MAX_ADDR_W'(id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
      id_entry.rs_used[i] = id_valid & id_rs_used[i];
    end
  end

  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_entry.rs_used[i] && (id_entry.rs[i] == ex_q.rd)) begin
        id_hit = 1'b1;
      end
    end
  end

  assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_hit;

  always_comb begin
    action = ACT_NORMAL;
    if (reset)             action = ACT_RESET;
    else if (branch_taken) action = ACT_FLUSH;
    else if (ex_busy)      action = ACT_BUSY;
    else if (load_use)     action = ACT_LOAD_USE;
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_write   = 1'b1;
    exmem_bubble = 1'b0;
    ex_kill      = 1'b0;
    case (action)
      ACT_RESET: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        ex_kill      = 1'b1;
      end
      ACT_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        // A MEM-resolved branch also squashes the younger instruction leaving EX.
        if (BRANCH_STAGE == BRANCH_MEM) begin
          exmem_bubble = 1'b1;
          ex_kill      = ex_busy;
        end
      end
      ACT_BUSY: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (action)
        ACT_FLUSH: begin
          ex_q      <= '0;
          mem_q     <= (BRANCH_STAGE == BRANCH_MEM) ? shadow_entry_t'('0) : ex_q;
          wb_q      <= mem_q;
          flush_cnt <= flush_cnt + CNT_W'(1);
        end
        ACT_BUSY: begin
          mem_q     <= '0;
          wb_q      <= mem_q;
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
        ACT_LOAD_USE: begin
          ex_q      <= '0;
          mem_q     <= ex_q;
          wb_q      <= mem_q;
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
        default: begin
          ex_q  <= id_entry;
          mem_q <= ex_q;
          wb_q  <= mem_q;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel_e sel;
    forward_select u_forward_select (
      .src       (ex_q.rs[g]),
      .src_used  (ex_q.rs_used[g]),
      .mem_entry (mem_q),
      .wb_entry  (wb_q),
      .sel       (sel)
    );
    assign fwd_sel[g*2 +: 2] = reset ? FWD_REG : sel;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed bench for hazard_control_unit at both branch stages
module tb_hazard_control_unit;

  typedef struct packed {
    logic            v;
    logic [4:0]      rd;
    logic            wr;
    logic            ld;
    logic [1:0][4:0] rs;
    logic [1:0]      used;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        branch_taken;
  logic        ex_busy;

  // index 0: BRANCH_STAGE=2, index 1: BRANCH_STAGE=3
  logic [1:0]  pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_bubble, ex_kill;
  logic [3:0]  fwd_sel   [2];
  logic [31:0] stall_cnt [2];
  logic [31:0] flush_cnt [2];

  int n_checks = 0;
  int n_pass   = 0;

  instr_t      st [2][3];   // [dut][0=EX,1=MEM,2=WB]
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    hazard_control_unit #(.BRANCH_STAGE(d + 2)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .id_memread   (id_memread),
      .branch_taken (branch_taken),
      .ex_busy      (ex_busy),
      .pc_write     (pc_write[d]),
      .ifid_write   (ifid_write[d]),
      .ifid_flush   (ifid_flush[d]),
      .idex_bubble  (idex_bubble[d]),
      .idex_write   (idex_write[d]),
      .exmem_bubble (exmem_bubble[d]),
      .ex_kill      (ex_kill[d]),
      .fwd_sel      (fwd_sel[d]),
      .stall_cnt    (stall_cnt[d]),
      .flush_cnt    (flush_cnt[d])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic instr_t id_instr();
    instr_t t = '0;
    if (id_valid) begin
      t.v = 1'b1; t.rd = id_rd; t.wr = id_regwrite; t.ld = id_memread;
      t.rs = id_rs; t.used = id_rs_used;
    end
    return t;
  endfunction

  function automatic bit model_load_use(int d);
    instr_t ex = st[d][0];
    bit hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (id_rs_used[i] && id_rs[i*5 +: 5] == ex.rd) hit = 1'b1;
    return id_valid && ex.v && ex.ld && ex.rd != 0 && hit;
  endfunction

  // 0 reset, 1 flush, 2 busy, 3 load-use, 4 normal
  function automatic int model_action(int d);
    if (reset)        return 0;
    if (branch_taken) return 1;
    if (ex_busy)      return 2;
    if (model_load_use(d)) return 3;
    return 4;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_bubble, ex_kill}
  function automatic logic [6:0] model_ctrl(int a, int stg);
    case (a)
      0: return 7'b0011011;
      1: return {5'b11111, stg == 3, stg == 3 && ex_busy};
      2: return 7'b0000010;
      3: return 7'b0001100;
      default: return 7'b1100100;
    endcase
  endfunction

  function automatic logic [1:0] model_fwd(int d, int i);
    instr_t ex = st[d][0];
    if (!ex.v || !ex.used[i]) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (st[d][s].v && st[d][s].wr && st[d][s].rd != 0 && st[d][s].rd == ex.rs[i])
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] dut_ctrl(int d);
    return {pc_write[d], ifid_write[d], ifid_flush[d], idex_bubble[d],
            idex_write[d], exmem_bubble[d], ex_kill[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) st[d][s] = '0;
      m_stall[d] = 0;
      m_flush[d] = 0;
    end
  endtask

  task automatic cycle();
    int     acts [2];
    instr_t nxt;
    #4;
    for (int d = 0; d < 2; d++) begin
      logic [3:0] ef;
      acts[d] = model_action(d);
      for (int i = 0; i < 2; i++) ef[i*2 +: 2] = (acts[d] == 0) ? 2'b00 : model_fwd(d, i);
      check($sformatf("ctrl_bs%0d", d + 2), 32'(dut_ctrl(d)), 32'(model_ctrl(acts[d], d + 2)));
      check($sformatf("fwd_bs%0d", d + 2), 32'(fwd_sel[d]), 32'(ef));
      check($sformatf("stall_cnt_bs%0d", d + 2), stall_cnt[d], m_stall[d]);
      check($sformatf("flush_cnt_bs%0d", d + 2), flush_cnt[d], m_flush[d]);
    end
    nxt = id_instr();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      instr_t ex  = st[d][0];
      instr_t mem = st[d][1];
      case (acts[d])
        0: begin
          for (int s = 0; s < 3; s++) st[d][s] = '0;
          m_stall[d] = 0; m_flush[d] = 0;
        end
        1: begin
          st[d][0] = '0; st[d][1] = (d == 1) ? instr_t'('0) : ex; st[d][2] = mem;
          m_flush[d]++;
        end
        2: begin
          st[d][1] = '0; st[d][2] = mem;
          m_stall[d]++;
        end
        3: begin
          st[d][0] = '0; st[d][1] = ex; st[d][2] = mem;
          m_stall[d]++;
        end
        default: begin
          st[d][0] = nxt; st[d][1] = ex; st[d][2] = mem;
        end
      endcase
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit wr, input bit ld,
                       input bit br = 1'b0, input bit busy = 1'b0);
    id_valid     = v;
    id_rs        = {5'(rs1), 5'(rs0)};
    id_rs_used   = used;
    id_rd        = 5'(rd);
    id_regwrite  = wr;
    id_memread   = ld;
    branch_taken = br;
    ex_busy      = busy;
  endtask

  task automatic nop();
    drive(0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3
    drive(1, 1, 2, 2'b11, 5, 1, 0); cycle();
    drive(1, 5, 3, 2'b11, 6, 1, 0); cycle();
    nop(); #1 check("dir_fwd_mem", 32'(fwd_sel[1][1:0]), 32'b10); cycle();
    // add x5 ; and x9 ; sub x6,x5,x3
    drive(1, 1, 2, 2'b11, 5, 1, 0); cycle();
    drive(1, 10, 11, 2'b11, 9, 1, 0); cycle();
    drive(1, 5, 3, 2'b11, 6, 1, 0); cycle();
    nop(); #1 check("dir_fwd_wb", 32'(fwd_sel[1][1:0]), 32'b01); cycle();
    // x5 written twice in a row, then read
    drive(1, 1, 2, 2'b11, 5, 1, 0); cycle();
    drive(1, 7, 0, 2'b01, 5, 1, 0); cycle();
    drive(1, 5, 3, 2'b11, 6, 1, 0); cycle();
    nop(); #1 check("dir_fwd_both", 32'(fwd_sel[1][1:0]), 32'b10); cycle();

    // ld x7,0(x1) ; add x8,x7,x2
    drive(1, 1, 0, 2'b01, 7, 1, 1); cycle();
    drive(1, 7, 2, 2'b11, 8, 1, 0);
    #1 check("lu_pc_write", 32'(pc_write[1]), 0);
    check("lu_idex_bubble", 32'(idex_bubble[1]), 1);
    cycle();
    #1 check("lu_released", 32'(pc_write[1]), 1);
    cycle();
    nop(); #1 check("lu_fwd_wb", 32'(fwd_sel[1][1:0]), 32'b01);
    check("lu_stall_cnt", stall_cnt[1], 1);
    cycle();

    // x0 is never a hazard or forwarding source
    drive(1, 1, 0, 2'b01, 0, 1, 1); cycle();
    drive(1, 0, 0, 2'b11, 9, 1, 0);
    #1 check("x0_no_stall", 32'(pc_write[1]), 1);
    cycle();
    nop(); #1 check("x0_fwd_reg", 32'(fwd_sel[1]), 0); cycle();

    // taken branch
    drive(1, 1, 2, 2'b11, 4, 1, 0); cycle();
    drive(1, 4, 0, 2'b01, 3, 1, 0, 1'b1);
    #1 check("br3_flush_bubbles", 32'({ifid_flush[1], idex_bubble[1], exmem_bubble[1]}), 32'b111);
    check("br2_exmem_bubble", 32'(exmem_bubble[0]), 0);
    cycle();
    nop(); #1 check("br3_flush_cnt", flush_cnt[1], 1);
    check("br2_flush_cnt", flush_cnt[0], 1);
    check("br3_younger_dropped", 32'(fwd_sel[1]), 0);
    cycle();

    // four busy cycles
    drive(1, 1, 2, 2'b11, 5, 1, 0); cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, 0, 2'b01, 6, 1, 0, 1'b0, 1'b1);
      #1 check($sformatf("busy_hold_%0d", k), 32'({pc_write[1], exmem_bubble[1]}), 32'b01);
      cycle();
    end
    drive(1, 5, 0, 2'b01, 6, 1, 0);
    #1 check("busy_stall_cnt", stall_cnt[1], 5);
    check("busy_done", 32'(pc_write[1]), 1);
    cycle();

    // branch during busy, then reset on a branch+busy cycle
    drive(1, 1, 2, 2'b11, 5, 1, 0, 1'b0, 1'b1); cycle();
    drive(1, 1, 2, 2'b11, 5, 1, 0, 1'b1, 1'b1);
    #1 check("br_busy_kill", 32'(ex_kill[1]), 1);
    check("br_busy_pc", 32'(pc_write[1]), 1);
    cycle();
    drive(1, 1, 2, 2'b11, 5, 1, 0, 1'b1, 1'b1);
    reset = 1'b1;
    #1 check("rst_over_all", 32'(dut_ctrl(1)), 32'b0011011);
    cycle();
    reset = 1'b0;
    nop(); #1 check("rst_stall_zero", stall_cnt[1], 0);
    check("rst_flush_zero", flush_cnt[1], 0);
    cycle();

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 5) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
